// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   mode_t : 2-bit shift mode (SLL, SRL, SRA, ROL), encoded as on in_mode.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: conditionally shifts by 2^STAGE
// (when bit STAGE of the carried amount is set) and registers the result.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : advance enable (low = hold, bubbles included)
//   prev_*       : beat from the previous stage (or the input port)
//   valid/data/amt/mode : registered beat for the next stage
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH),
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [SHW-1:0]   prev_amt,
  input  mode_t            prev_mode,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   amt,
  output mode_t            mode
);

  localparam int S = 1 << STAGE;

  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   amt_next;

  always_comb begin
    shifted = prev_data;
    if (prev_amt[STAGE]) begin
      case (prev_mode)
        MODE_SLL: shifted = prev_data << S;
        MODE_SRL: shifted = prev_data >> S;
        // MSB never changes across stages, so it is still the original sign
        MODE_SRA: shifted = {{S{prev_data[WIDTH-1]}}, prev_data[WIDTH-1:S]};
        MODE_ROL: shifted = {prev_data[WIDTH-1-S:0], prev_data[WIDTH-1:WIDTH-S]};
        default:  shifted = prev_data;
      endcase
    end
  end

  // Residual amount: the bit this stage consumed is cleared
  always_comb begin
    amt_next        = prev_amt;
    amt_next[STAGE] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      amt   <= '0;
      mode  <= MODE_SLL;
    end else if (en) begin
      valid <= prev_valid;
      data  <= shifted;
      amt   <= amt_next;
      mode  <= prev_mode;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter, one log2 shift stage per clock, valid/ready on
// both sides. Latency SHW cycles, throughput one beat per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_data/in_amt/in_mode : operand, shift amount, mode (SLL/SRL/SRA/ROL)
//   out_valid/out_ready  : output handshake
//   out_data             : shifted result (last-stage register)
//   out_zero             : out_data == 0 (consumer qualifies with out_valid)
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // Index 0 is the input port; index k+1 is the register of stage k
  logic [SHW:0]     v;
  logic [WIDTH-1:0] d [SHW+1];
  logic [SHW-1:0]   a [SHW+1];
  mode_t            m [SHW+1];
  logic             stall;

  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign a[0] = in_amt;
  assign m[0] = mode_t'(in_mode);

  // Whole pipeline freezes on output backpressure; bubbles are kept
  assign stall    = v[SHW] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .STAGE (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (~stall),
      .prev_valid (v[k]),
      .prev_data  (d[k]),
      .prev_amt   (a[k]),
      .prev_mode  (m[k]),
      .valid      (v[k+1]),
      .data       (d[k+1]),
      .amt        (a[k+1]),
      .mode       (m[k+1])
    );
  end

  assign out_valid = v[SHW];
  assign out_data  = d[SHW];
  assign out_zero  = ~|d[SHW];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_amt = '0;
  logic [1:0]    in_mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_zero;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]  bd [16];
  logic [SW-1:0] ba [16];
  logic [1:0]    bm [16];
  logic [W-1:0]  be [16];

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_beat(input int i, input logic [W-1:0] dd, input logic [SW-1:0] aa,
                          input logic [1:0] mm, input logic [W-1:0] ee);
    bd[i] = dd; ba[i] = aa; bm[i] = mm; be[i] = ee;
  endtask

  // Drives n beats, collects results in order, checks data/zero/latency,
  // stall behaviour and hold stability. Optional stall window and bubbles.
  task automatic stream(input string tag, input int n, input int st_at, input int st_len,
                        input bit bubble);
    int snd = 0;
    int rcv = 0;
    int acc_cyc [16];
    logic [W-1:0] held = '0;
    bit holding = 1'b0;
    for (int cyc = 0; cyc < 200 && rcv < n; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(st_len > 0 && cyc >= st_at && cyc < st_at + st_len);
      if (snd < n && (!bubble || (cyc % 2) == 0)) begin
        in_valid = 1'b1; in_data = bd[snd]; in_amt = ba[snd]; in_mode = bm[snd];
      end else begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_amt   = SW'($urandom);
        in_mode  = 2'($urandom);
      end
      #1;
      if (out_valid && out_ready) begin
        chk({tag, "_data"}, out_data, be[rcv]);
        chk({tag, "_zero"}, out_zero, (be[rcv] == '0));
        if (st_len == 0) chk({tag, "_latency"}, cyc, acc_cyc[rcv] + SW);
        rcv++;
        holding = 1'b0;
      end else if (out_valid) begin
        chk({tag, "_in_ready_stall"}, in_ready, 1'b0);
        if (holding) chk({tag, "_hold"}, out_data, held);
        else begin held = out_data; holding = 1'b1; end
      end else begin
        chk({tag, "_in_ready"}, in_ready, 1'b1);
      end
      if (in_valid && in_ready) begin
        acc_cyc[snd] = cyc;
        snd++;
      end
    end
    chk({tag, "_count"}, rcv, n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_tail_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_data", out_data, 16'h0000);
      chk("idle_zero", out_zero, 1'b1);
      chk("idle_in_ready", in_ready, 1'b1);
    end

    // Back-to-back SLL
    set_beat(0, 16'h000A, 4'd1, 2'b00, 16'h0014);
    set_beat(1, 16'h0080, 4'd2, 2'b00, 16'h0200);
    set_beat(2, 16'h0800, 4'd7, 2'b00, 16'h0000);
    stream("b2b", 3, -1, 0, 1'b0);

    // Mode sweep and boundary amounts
    set_beat(0,  16'h8001, 4'd4,  2'b00, 16'h0010);
    set_beat(1,  16'h8001, 4'd4,  2'b01, 16'h0800);
    set_beat(2,  16'h8001, 4'd4,  2'b10, 16'hF800);
    set_beat(3,  16'h8001, 4'd4,  2'b11, 16'h0018);
    set_beat(4,  16'h8001, 4'd0,  2'b00, 16'h8001);
    set_beat(5,  16'h8001, 4'd0,  2'b01, 16'h8001);
    set_beat(6,  16'h8001, 4'd0,  2'b10, 16'h8001);
    set_beat(7,  16'h8001, 4'd0,  2'b11, 16'h8001);
    set_beat(8,  16'h8000, 4'd15, 2'b10, 16'hFFFF);
    set_beat(9,  16'h8001, 4'd15, 2'b11, 16'hC000);
    set_beat(10, 16'h0001, 4'd15, 2'b00, 16'h8000);
    set_beat(11, 16'h8001, 4'd15, 2'b01, 16'h0001);
    set_beat(12, 16'h7FFE, 4'd15, 2'b00, 16'h0000);
    stream("sweep", 13, -1, 0, 1'b0);

    // Backpressure: 6 beats, out_ready low for 3 cycles mid-stream
    set_beat(0, 16'h0001, 4'd1, 2'b00, 16'h0002);
    set_beat(1, 16'h0001, 4'd2, 2'b00, 16'h0004);
    set_beat(2, 16'h0001, 4'd3, 2'b00, 16'h0008);
    set_beat(3, 16'hF000, 4'd4, 2'b01, 16'h0F00);
    set_beat(4, 16'hF000, 4'd4, 2'b10, 16'hFF00);
    set_beat(5, 16'hF001, 4'd4, 2'b11, 16'h001F);
    stream("bp", 6, 5, 3, 1'b0);

    // Bubbles: alternate in_valid, stray data while idle
    set_beat(0, 16'h1234, 4'd4, 2'b00, 16'h2340);
    set_beat(1, 16'h1234, 4'd4, 2'b01, 16'h0123);
    set_beat(2, 16'hF00F, 4'd8, 2'b10, 16'hFFF0);
    set_beat(3, 16'h1234, 4'd8, 2'b11, 16'h3412);
    stream("bubble", 4, -1, 0, 1'b1);

    // Reset with 3 beats in flight
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h1111; in_amt = 4'd1; in_mode = 2'b00;
    @(posedge clk); #1;
    in_data = 16'h2222;
    @(posedge clk); #1;
    in_data = 16'h3333;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_data", out_data, 16'h0000);
    chk("async_rst_zero", out_zero, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", out_valid, 1'b0);
    end
    set_beat(0, 16'h0003, 4'd1, 2'b11, 16'h0006);
    stream("post_rst", 1, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined successor to the 16-bit combinational left barrel shifter. It supports four shift modes and pipelines one log2 stage per clock. A valid/ready handshake at both ends provides backpressure. It sits between the datapath operand registers and the ALU result mux, and lets shifts at WIDTH=32/64 close timing.

Parameters:
WIDTH, 16, data width in bits; must be a power of two, 8..64.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat present
in_ready  output  1  shifter can accept a beat this cycle
in_data  input  WIDTH  operand
in_amt  input  SHW  shift amount, 0..WIDTH-1
in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  shifted result
out_zero  output  1  out_data == 0

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n), clock is clk.
- Reset state: every stage valid bit = 0, every stage data/amt/mode register = 0. Therefore out_valid=0, out_data=0, out_zero=1. in_ready=1 from the first cycle after rst_n deasserts.
- Pipeline structure:
  - SHW stages; stage k (k=0..SHW-1) applies a shift of 2^k when bit k of the carried amount is 1, otherwise passes data through.
  - Each stage registers data, residual amount, mode, and valid.
  - out_* are driven directly from the last stage registers.
- Latency: accepted beat appears on out_* exactly SHW cycles after the accept edge when there is no stall (WIDTH=16: 4 cycles).
- Throughput: one beat per cycle.
- Handshake:
  - Global stall = out_valid & ~out_ready. in_ready = ~stall.
  - Accept occurs when in_valid & in_ready.
  - On stall, all stages hold, including bubbles; bubbles are not collapsed.
  - When not stalled, every stage advances. A stage whose predecessor holds no beat loads valid=0.
  - out_data/out_zero must stay stable while out_valid=1 and out_ready=0.
- Mode arithmetic per stage, shift s=2^k:
  - SLL: zero-fill from LSB.
  - SRL: zero-fill from MSB.
  - SRA: fill with the original sign bit. The MSB is invariant through all stages, so the current MSB is used.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- Boundary conditions:
  - Amount 0: data passes unchanged in all modes, same latency.
  - Amount WIDTH-1:
    - SLL leaves only bit0 in the MSB.
    - SRA of a negative operand gives all ones.
    - ROL by WIDTH-1 equals rotate right by 1.
  - in_valid=0 while in_ready=1 inserts a bubble. Stray data on in_data is ignored and not propagated as valid.
  - Simultaneous accept and output consume in the same cycle is a normal full-throughput case.
- Reset mid-operation: all in-flight beats are discarded immediately (asynchronous). No partial results after release.
- out_zero is combinational from the last-stage data register. It is qualified by out_valid only by the consumer.

Decomposition:
- Shared package shifter_pkg:
  - mode localparams MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_ROL=2'b11;
  - the 2-bit mode type.
- Sub-module shift_stage, parameters WIDTH, SHW, STAGE:
  - one conditional 2^STAGE shift plus its valid/data/amt/mode registers, with an enable input;
  - the top instantiates SHW of them in a generate loop and computes stall/in_ready.

Test Plan:
1. Reset, then hold in_valid=0 for 8 cycles: out_valid=0, out_data=0, out_zero=1, in_ready=1 throughout.
2. WIDTH=16, out_ready=1, back-to-back beats on consecutive cycles:
   - {0x000A, amt 1, SLL}, {0x0080, amt 2, SLL}, {0x0800, amt 7, SLL};
   - outputs 0x0014, 0x0200, 0x0000 (out_zero=1) on 3 consecutive cycles starting 4 cycles after the first accept.
3. Mode sweep on 0x8001, amt 4: SLL gives 0x0010, SRL gives 0x0800, SRA gives 0xF800, ROL gives 0x0018. Amt 0 in every mode gives 0x8001. SRA of 0x8000 by 15 gives 0xFFFF.
4. Backpressure: stream 6 beats, drop out_ready for 3 cycles mid-stream.
   - in_ready=0 during the stall;
   - out_data held stable;
   - all 6 results delivered in order, none lost or duplicated.
5. Bubbles: alternate in_valid 1/0 for 8 cycles with out_ready=1: out_valid alternates with the same spacing and the correct results.
6. Assert rst_n low for 1 cycle while 3 beats are in flight: out_valid drops asynchronously. After release, none of the 3 appear; a fresh beat {0x0003, amt 1, ROL} yields 0x0006 after 4 cycles.
